dmem_byte_streamer: RTL and testbench



---
 rtl/dmem_byte_streamer_if.sv | 20 ++
 rtl/dmem_byte_streamer.sv | 129 ++++++++++++
 tb/tb_dmem_byte_streamer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_byte_streamer_if.sv
// Byte-stream and data-RAM read-port bundle for dmem_byte_streamer.
// The master side drives the RAM address and sources the byte stream.
interface dmem_byte_streamer_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output mem_addr, out_valid, out_data, out_last,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_data, out_last,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/dmem_byte_streamer.sv
// Walks a word-aligned data-RAM region over the read-only port and emits
// each word as four little-endian bytes on a valid/ready stream.
module dmem_byte_streamer #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     num_words,
  output logic                 busy,
  output logic                 done,
  dmem_byte_streamer_if.master bus
);

  if (CNT_W < $clog2(MAX_WORDS + 1)) begin : g_cnt_w_check
    $error("CNT_W cannot hold MAX_WORDS");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [31:0]      ptr, ptr_d;
  logic [31:0]      word_reg, word_d;
  logic [1:0]       byte_idx, idx_d;
  logic [CNT_W-1:0] words_left, left_d;
  logic             busy_d, done_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       data_q, data_d;

  // State and datapath registers; stream outputs are registered copies
  // of the next-cycle view so they hold steady across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      word_reg   <= '0;
      byte_idx   <= '0;
      words_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      word_reg   <= word_d;
      byte_idx   <= idx_d;
      words_left <= left_d;
      busy       <= busy_d;
      done       <= done_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    word_d  = word_reg;
    idx_d   = byte_idx;
    left_d  = words_left;
    done_d  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            ptr_d   = base_addr & 32'hFFFF_FFFC;
            left_d  = num_words;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          word_d  = bus.mem_rdata;
          ptr_d   = ptr + 32'd4;
          idx_d   = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (valid_q && bus.out_ready) begin
          if (byte_idx != 2'd3) begin
            idx_d = byte_idx + 2'd1;
          end else if (words_left > CNT_W'(1)) begin
            // ptr already addresses the next word: prefetch with no bubble
            word_d = bus.mem_rdata;
            ptr_d  = ptr + 32'd4;
            left_d = words_left - CNT_W'(1);
            idx_d  = 2'd0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_SEND);
    data_d  = valid_d ? 8'(word_d >> {idx_d, 3'b000}) : 8'h00;
    last_d  = valid_d && (left_d == CNT_W'(1)) && (idx_d == 2'd3);
  end

  assign bus.mem_addr  = ptr;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_dmem_byte_streamer.sv
// Randomized self-checking bench for dmem_byte_streamer against a
// word-list/byte-queue reference model of the transfer.
module tb_dmem_byte_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] base_addr;
  logic [10:0] num_words;
  logic        busy, done;
  logic        ready;
  logic [31:0] ram [0:1023];

  int total = 0;
  int bad   = 0;

  dmem_byte_streamer_if bus_if ();

  dmem_byte_streamer #(.MAX_WORDS(1024), .CNT_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .bus       (bus_if.master)
  );

  assign bus_if.mem_rdata = ram[bus_if.mem_addr[11:2]];
  assign bus_if.out_ready = ready;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: expected byte sequence of a transfer.
  logic [7:0] exp_q[$];
  function automatic void build_exp(input logic [31:0] b, input int n);
    exp_q.delete();
    for (int w = 0; w < n; w++) begin
      int unsigned widx = ((b / 4) + w) % 1024;
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((ram[widx] >> (8 * k)) & 32'hFF));
    end
  endfunction

  // Observations of the last stream() run.
  logic [7:0] got_q[$];
  bit         last_q[$];
  int first_valid, done_cnt, done_at, busy_at_done, busy_seen, viol, hs;
  int post_abort_valid, post_abort_busy, late_valid;
  bit timeout;

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic stream(input logic [31:0] b, input int n, input int mode,
                        input int abort_after, input int budget);
    int cyc, abort_cyc;
    bit prev_stall;
    logic [7:0] pd;
    logic pl;
    got_q.delete(); last_q.delete();
    first_valid = -1; done_cnt = 0; done_at = -1; busy_at_done = 0; busy_seen = 0;
    viol = 0; hs = 0; post_abort_valid = 0; post_abort_busy = 0; late_valid = 0;
    timeout = 0; abort_cyc = -1; prev_stall = 0; pd = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_words = 11'(n); ready = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 3 == 2);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_after > 0 && hs == abort_after && abort_cyc < 0) begin
        abort = 1'b1; ready = 1'b0; abort_cyc = cyc;
      end
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        post_abort_valid = bus_if.out_valid; post_abort_busy = busy;
      end
      if (abort_cyc > 0 && cyc > abort_cyc + 1 && bus_if.out_valid) late_valid++;
      if (busy) busy_seen++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = cyc; busy_at_done = busy; end
      end
      if (bus_if.out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!bus_if.out_valid || bus_if.out_data !== pd || bus_if.out_last !== pl)) viol++;
      prev_stall = bus_if.out_valid && !ready && !abort;
      pd = bus_if.out_data; pl = bus_if.out_last;
      if (bus_if.out_valid && ready) begin
        got_q.push_back(bus_if.out_data); last_q.push_back(bus_if.out_last); hs++;
      end
      if (done_at > 0 && cyc >= done_at + 2) break;
      if (abort_cyc > 0 && cyc >= abort_cyc + 4) break;
      if (cyc >= budget) begin timeout = (abort_after == 0); break; end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, bus_if.out_valid, bus_if.out_last} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b required 0000", {busy, done, bus_if.out_valid, bus_if.out_last});
    end
    total++;
    if (bus_if.out_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %h required 00", bus_if.out_data);
    end
    total++;
    if (bus_if.mem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_addr: got %h required 0", bus_if.mem_addr);
    end
  endtask

  task automatic test_basic();
    ram[0] = 32'h4433_2211; ram[1] = 32'h8877_6655;
    build_exp(32'h0, 2);
    stream(32'h0, 2, 0, 0, 50);
    total++; if (timeout) begin bad++; $display("FAIL basic_timeout: no done within budget"); end
    total++; if (first_valid != 2) begin bad++; $display("FAIL basic_latency: got %0d required 2", first_valid); end
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL basic_count: got %0d required 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      total++;
      if (last_q[i] != (i == 7)) begin bad++; $display("FAIL basic_last%0d: got %0d required %0d", i, last_q[i], i == 7); end
    end
    total++; if (done_cnt != 1 || done_at != 10) begin
      bad++; $display("FAIL basic_done: got count %0d at %0d required 1 at 10", done_cnt, done_at);
    end
    total++; if (busy_at_done != 0) begin bad++; $display("FAIL basic_busy_fall: got %0d required 0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    build_exp(32'h0, 2);
    stream(32'h0, 2, 1, 0, 100);
    total++; if (timeout || hs != 8) begin bad++; $display("FAIL bp_handshakes: got %0d required 8", hs); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || last_q[i] != (i == 7)) begin
        bad++; $display("FAIL bp_byte%0d: got %h/%0d required %h/%0d", i, got_q[i], last_q[i], exp_q[i], i == 7);
      end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL bp_hold: got %0d stall violations required 0", viol); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    stream(32'h40, 0, 0, 0, 20);
    total++; if (done_cnt != 1 || done_at != 1) begin
      bad++; $display("FAIL zero_done: got count %0d at %0d required 1 at 1", done_cnt, done_at);
    end
    total++; if (first_valid != -1) begin bad++; $display("FAIL zero_valid: got valid at %0d required never", first_valid); end
    total++; if (busy_seen != 0) begin bad++; $display("FAIL zero_busy: got %0d busy cycles required 0", busy_seen); end
  endtask

  task automatic test_wrap();
    ram[1023] = 32'hDDCC_BBAA; ram[0] = 32'h0403_0201;
    build_exp(32'h0000_0FFE, 2);
    stream(32'h0000_0FFE, 2, 0, 0, 50);
    total++; if (timeout || got_q.size() != 8) begin bad++; $display("FAIL wrap_count: got %0d required 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) ram[i] = $urandom;
    build_exp(32'h0, 4);
    stream(32'h0, 4, 0, 3, 60);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL abort_count: got %0d required 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    total++; if (post_abort_valid != 0 || post_abort_busy != 0) begin
      bad++; $display("FAIL abort_stop: got valid %0d busy %0d required 0 0", post_abort_valid, post_abort_busy);
    end
    total++; if (done_cnt != 0 || late_valid != 0) begin
      bad++; $display("FAIL abort_quiet: got done %0d late valid %0d required 0 0", done_cnt, late_valid);
    end
    build_exp(32'h10, 2);
    stream(32'h10, 2, 0, 0, 50);
    total++; if (timeout || got_q.size() != 8 || done_cnt != 1) begin
      bad++; $display("FAIL restart_count: got %0d bytes %0d done required 8 1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    ram[0] = 32'h4433_2211; ram[1] = 32'h8877_6655;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0; num_words = 11'd2; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, bus_if.out_valid, bus_if.out_last} !== 4'b0 || bus_if.out_data !== 8'h00 || bus_if.mem_addr !== 32'h0) begin
      bad++; $display("FAIL areset_outputs: got flags %b data %h addr %h required 0", {busy, done, bus_if.out_valid, bus_if.out_last}, bus_if.out_data, bus_if.mem_addr);
    end
    ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    build_exp(32'h0, 2);
    stream(32'h0, 2, 0, 0, 50);
    total++; if (first_valid != 2 || done_at != 10 || got_q.size() != 8) begin
      bad++; $display("FAIL areset_rerun: got first %0d done %0d bytes %0d required 2 10 8", first_valid, done_at, got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL areset_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [31:0] b;
      int n;
      for (int i = 0; i < 1024; i++) ram[i] = $urandom;
      b = $urandom;
      if (t % 3 == 0) b = 32'h0000_0FF0 | (b & 32'hF);
      n = $urandom_range(1, 9);
      build_exp(b, n);
      stream(b, n, 2, 0, 300);
      total++; if (timeout || got_q.size() != exp_q.size() || done_cnt != 1) begin
        bad++; $display("FAIL rand%0d_count: got %0d bytes %0d done required %0d 1", t, got_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i] || last_q[i] != (i == exp_q.size() - 1)) begin
          bad++; $display("FAIL rand%0d_byte%0d: got %h/%0d required %h/%0d", t, i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
        end
      end
      total++; if (viol != 0) begin bad++; $display("FAIL rand%0d_hold: got %0d violations required 0", t, viol); end
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    base_addr = '0; num_words = '0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    #1 rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
